// File: rtl/booth_pkg.sv
// Shared constants and the result-FIFO entry type for the Booth multiplier
// back end (multiplier pipeline and product accumulator).
package booth_pkg;
  localparam int MUL_LATENCY    = 8;
  localparam int PROD_W         = 16;
  localparam int ACC_W_MAX      = 24;
  localparam int CNT_W_MAX      = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int FIFO_PTR_W     = $clog2(FIFO_DEPTH_DEF);

  // Fields are sized for the widest supported configuration. Narrower
  // accumulators store a sign-extended sum and read back the low bits.
  typedef struct packed {
    logic [ACC_W_MAX-1:0] data;
    logic [CNT_W_MAX-1:0] terms;
    logic                 ovf;
  } acc_result_t;
endpackage

// File: rtl/booth_product_accumulator_fifo.sv
// Synchronous show-ahead result FIFO. A push while full is accepted only when a
// pop happens in the same cycle.
module acc_result_fifo
  import booth_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  acc_result_t din,
  input  logic        pop,
  output acc_result_t dout,
  output logic        empty,
  output logic        full,
  output logic [AW:0] free
);
  acc_result_t       mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       cnt;
  logic              do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign free    = (AW+1)'(DEPTH) - cnt;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/booth_product_accumulator.sv
// Accumulates products from the unstallable Booth multiplier into dot-product
// results, queues them in a small FIFO and issues credit for last terms.
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int LATENCY    = MUL_LATENCY,
  parameter int PROD_W     = booth_pkg::PROD_W,
  parameter int ACC_W      = 24,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_last,
  input  logic [PROD_W-1:0] product,
  output logic              issue_ok,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]  acc_terms,
  output logic              acc_ovf,
  output logic              err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(LATENCY+1);

  logic [LATENCY-1:0]       vld_pipe, lst_pipe;
  logic                     d_valid, d_last;
  logic [IW-1:0]            inflight;
  logic signed [ACC_W-1:0]  sext, base, acc, acc_next;
  logic [CNT_W-1:0]         cnt, cnt_base, cnt_next;
  logic                     ovf, ovf_next, first;
  logic                     push, pop, empty, full;
  logic [AW:0]              free;
  acc_result_t              din, head;

  assign d_valid = vld_pipe[LATENCY-1];
  assign d_last  = lst_pipe[LATENCY-1];

  assign sext     = ACC_W'(signed'(product));
  assign base     = first ? '0 : acc;
  assign acc_next = base + sext;
  assign ovf_next = (first ? 1'b0 : ovf) |
                    ((base[ACC_W-1] == sext[ACC_W-1]) && (acc_next[ACC_W-1] != base[ACC_W-1]));
  assign cnt_base = first ? '0 : cnt;
  assign cnt_next = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;

  assign push = d_valid && d_last;
  assign pop  = acc_valid && acc_ready;

  always_comb begin
    din       = '0;
    din.data  = ACC_W_MAX'(acc_next);
    din.terms = CNT_W_MAX'(cnt_next);
    din.ovf   = ovf_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      lst_pipe <= '0;
      inflight <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      first    <= 1'b1;
      err      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[LATENCY-2:0], issue_valid};
      lst_pipe <= {lst_pipe[LATENCY-2:0], issue_valid & issue_last};
      inflight <= inflight + IW'(issue_valid & issue_last) - IW'(d_last);
      if (d_valid && !d_last) begin
        acc   <= acc_next;
        cnt   <= cnt_next;
        ovf   <= ovf_next;
        first <= 1'b0;
      end else if (push) begin
        first <= 1'b1;
      end
      if (push && full && !pop) err <= 1'b1;
    end
  end

  acc_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
    .dout(head), .empty(empty), .full(full), .free(free)
  );

  // Every last term already in the delay line needs a FIFO slot when it lands.
  assign issue_ok  = (32'(free) + 32'(pop)) > 32'(inflight);
  assign acc_valid = !empty;
  assign acc_data  = empty ? '0 : head.data[ACC_W-1:0];
  assign acc_terms = empty ? '0 : head.terms[CNT_W-1:0];
  assign acc_ovf   = !empty && head.ovf;
endmodule
